// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe -- pipelined RISC-V immediate generator for the decode stage.
//
// Takes one 32-bit instruction plus its PC per valid/ready handshake and
// extracts the sign-extended immediate (I, S, B, U, J formats), widened to
// XLEN. It also produces the PC-relative target for B, J and AUIPC, flags
// unknown opcodes, and counts accepted illegal instructions (saturating).
// Results sit in a 2-entry skid buffer (main + skid), so in_ready depends
// only on the state register and not on out_ready.
//
// Parameters
//   XLEN       datapath width of pc/imm/target (32 or 64)
//   ENABLE_UJ  1: decode LUI/AUIPC/JAL/JALR; 0: those opcodes are illegal
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake
//   in_instr, in_pc     instruction word and its PC
//   out_valid/out_ready output handshake
//   out_imm             sign-extended immediate
//   out_fmt             0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
//   out_target          pc + imm for B, J, AUIPC; otherwise 0
//   out_illegal         opcode not recognised
//   illegal_count       saturating count of accepted illegal instructions
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit ENABLE_UJ = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal,
    output logic [15:0]     illegal_count
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [2:0]      fmt;
        logic            illegal;
    } res_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    // ------------------------------------------------------------------
    // Decode (combinational, on the offered instruction)
    // ------------------------------------------------------------------
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic            dec_pcrel;
    res_t            dec;

    always_comb begin
        imm32       = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        dec_pcrel   = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011: begin
                dec_fmt = FMT_I;
                imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b1100111: begin
                // JALR: target needs rs1, which is not available here
                if (ENABLE_UJ) begin
                    dec_fmt = FMT_I;
                    imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_pcrel = 1'b1;
                imm32     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                if (ENABLE_UJ) begin
                    dec_fmt   = FMT_U;
                    dec_pcrel = in_instr[5] == 1'b0;  // AUIPC only, not LUI
                    imm32     = {in_instr[31:12], 12'b0};
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b1101111: begin
                if (ENABLE_UJ) begin
                    dec_fmt   = FMT_J;
                    dec_pcrel = 1'b1;
                    imm32     = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                 in_instr[20], in_instr[30:21], 1'b0};
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0110011: ;  // R-type: no immediate, still legal
            default: dec_illegal = 1'b1;
        endcase
    end

    // Every immediate's MSB is instr[31], so widening imm32 is a plain sext.
    generate
        if (XLEN > 32) begin : g_sext
            assign imm_x = {{(XLEN-32){imm32[31]}}, imm32};
        end else begin : g_nosext
            assign imm_x = imm32;
        end
    endgenerate

    always_comb begin
        dec.imm     = imm_x;
        dec.target  = dec_pcrel ? (in_pc + imm_x) : '0;
        dec.fmt     = dec_fmt;
        dec.illegal = dec_illegal;
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    res_t   main_q, skid_q;
    logic   accept, deliver;
    logic   load_main, load_skid, main_from_skid;

    assign in_ready  = (state_q != TWO) && !reset;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = ONE;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    load_main = 1'b1;          // replace in place, no bubble
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = TWO;
                end else if (deliver) begin
                    state_d   = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= EMPTY;
            main_q        <= '0;
            skid_q        <= '0;
            illegal_count <= '0;
        end else begin
            state_q <= state_d;
            if (load_main)      main_q <= dec;
            if (main_from_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= dec;
            if (accept && dec.illegal && (illegal_count != 16'hFFFF))
                illegal_count <= illegal_count + 16'd1;
        end
    end

    assign out_imm     = main_q.imm;
    assign out_target  = main_q.target;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three instances (XLEN=32, XLEN=64, and legacy
// ENABLE_UJ=0) share the same stimulus. A queue holds expected results per
// accepted instruction; the queue depth also predicts in_ready/out_valid.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_rdy, a_vld, a_ill;  logic [31:0] a_imm, a_tgt;  logic [2:0] a_fmt;  logic [15:0] a_cnt;
    logic        b_rdy, b_vld, b_ill;  logic [63:0] b_imm, b_tgt;  logic [2:0] b_fmt;  logic [15:0] b_cnt;
    logic        c_rdy, c_vld, c_ill;  logic [31:0] c_imm, c_tgt;  logic [2:0] c_fmt;  logic [15:0] c_cnt;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .ENABLE_UJ(1'b1)) d32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_rdy),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_vld), .out_ready(out_ready),
        .out_imm(a_imm), .out_fmt(a_fmt), .out_target(a_tgt), .out_illegal(a_ill),
        .illegal_count(a_cnt));

    imm_gen_pipe #(.XLEN(64), .ENABLE_UJ(1'b1)) d64 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_rdy),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_vld), .out_ready(out_ready),
        .out_imm(b_imm), .out_fmt(b_fmt), .out_target(b_tgt), .out_illegal(b_ill),
        .illegal_count(b_cnt));

    imm_gen_pipe #(.XLEN(32), .ENABLE_UJ(1'b0)) dlg (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_rdy),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(c_vld), .out_ready(out_ready),
        .out_imm(c_imm), .out_fmt(c_fmt), .out_target(c_tgt), .out_illegal(c_ill),
        .illegal_count(c_cnt));

    typedef struct packed {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } exp_t;

    typedef struct packed {
        exp_t e32;
        exp_t e64;
        exp_t elg;
    } sb_t;

    sb_t q[$];
    int  n_asrt = 0;
    int  n_fail = 0;
    int  cnt32 = 0, cnt64 = 0, cntlg = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode built straight from the instruction-format bit maps.
    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc,
                                   input bit x64, input bit uj);
        exp_t e;
        bit   pcrel;
        e     = '0;
        pcrel = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03: begin e.fmt = 3'd1; e.imm = {{52{ins[31]}}, ins[31:20]}; end
            7'h67: if (uj) begin e.fmt = 3'd1; e.imm = {{52{ins[31]}}, ins[31:20]}; end
                   else e.ill = 1'b1;
            7'h23: begin e.fmt = 3'd2; e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]}; end
            7'h63: begin
                e.fmt = 3'd3; pcrel = 1'b1;
                e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'h37: if (uj) begin e.fmt = 3'd4; e.imm = {{32{ins[31]}}, ins[31:12], 12'b0}; end
                   else e.ill = 1'b1;
            7'h17: if (uj) begin
                       e.fmt = 3'd4; pcrel = 1'b1;
                       e.imm = {{32{ins[31]}}, ins[31:12], 12'b0};
                   end else e.ill = 1'b1;
            7'h6F: if (uj) begin
                       e.fmt = 3'd5; pcrel = 1'b1;
                       e.imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
                   end else e.ill = 1'b1;
            7'h33: ;
            default: e.ill = 1'b1;
        endcase
        e.tgt = pcrel ? pc + e.imm : 64'd0;
        if (!x64) begin
            e.imm = e.imm & 64'h0000_0000_FFFF_FFFF;
            e.tgt = e.tgt & 64'h0000_0000_FFFF_FFFF;
        end
        return e;
    endfunction

    task automatic cmp_out(input string tag, input logic [63:0] imm, input logic [63:0] tgt,
                           input logic [2:0] fmt, input logic ill, input exp_t e);
        chk({tag, ".imm"}, imm, e.imm);
        chk({tag, ".target"}, tgt, e.tgt);
        chk({tag, ".fmt"}, {61'd0, fmt}, {61'd0, e.fmt});
        chk({tag, ".illegal"}, {63'd0, ill}, {63'd0, e.ill});
    endtask

    function automatic int sat(input int c, input logic ill);
        return (ill && c < 65535) ? c + 1 : c;
    endfunction

    // One clock: scoreboard work at the falling edge, return 1 after rising edge.
    task automatic tick();
        bit   acc, dlv;
        sb_t  s;
        @(negedge clk);
        if (reset) begin
            chk("rst.in_ready32", {63'd0, a_rdy}, 64'd0);
            chk("rst.in_ready64", {63'd0, b_rdy}, 64'd0);
            q.delete();
            cnt32 = 0; cnt64 = 0; cntlg = 0;
        end else begin
            chk("in_ready32", {63'd0, a_rdy}, {63'd0, q.size() < 2});
            chk("in_readylg", {63'd0, c_rdy}, {63'd0, q.size() < 2});
            chk("out_valid32", {63'd0, a_vld}, {63'd0, q.size() > 0});
            chk("out_valid64", {63'd0, b_vld}, {63'd0, q.size() > 0});
            chk("out_validlg", {63'd0, c_vld}, {63'd0, q.size() > 0});
            chk("count32", {48'd0, a_cnt}, 64'(cnt32));
            chk("count64", {48'd0, b_cnt}, 64'(cnt64));
            chk("countlg", {48'd0, c_cnt}, 64'(cntlg));
            acc = in_valid && (q.size() < 2);
            dlv = out_ready && (q.size() > 0);
            if (dlv) begin
                s = q.pop_front();
                cmp_out("d32", {32'd0, a_imm}, {32'd0, a_tgt}, a_fmt, a_ill, s.e32);
                cmp_out("d64", b_imm, b_tgt, b_fmt, b_ill, s.e64);
                cmp_out("dlg", {32'd0, c_imm}, {32'd0, c_tgt}, c_fmt, c_ill, s.elg);
            end
            if (acc) begin
                s.e32 = model(in_instr, {32'd0, in_pc[31:0]}, 1'b0, 1'b1);
                s.e64 = model(in_instr, in_pc, 1'b1, 1'b1);
                s.elg = model(in_instr, {32'd0, in_pc[31:0]}, 1'b0, 1'b0);
                q.push_back(s);
                cnt32 = sat(cnt32, s.e32.ill);
                cnt64 = sat(cnt64, s.e64.ill);
                cntlg = sat(cntlg, s.elg.ill);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        tick();
    endtask

    logic [31:0] rnd_ops [8];

    initial begin
        rnd_ops = '{32'h0000_0013, 32'h0000_0003, 32'h0000_0023, 32'h0000_0063,
                    32'h0000_0017, 32'h0000_006F, 32'h0000_0067, 32'h0000_007F};

        // Reset held 2 cycles while an instruction is offered
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF0_0093; in_pc = 64'h0; out_ready = 1'b0;
        tick(); tick();
        chk("rst.out_valid", {63'd0, a_vld}, 64'd0);
        chk("rst.imm", {32'd0, a_imm}, 64'd0);
        chk("rst.target", b_tgt, 64'd0);
        chk("rst.fmt", {61'd0, a_fmt}, 64'd0);
        chk("rst.illegal", {63'd0, a_ill}, 64'd0);
        chk("rst.count", {48'd0, a_cnt}, 64'd0);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("post_rst.in_ready", {63'd0, a_rdy}, 64'd1);
        tick();

        // Directed decodes with out_ready high (1-cycle latency)
        out_ready = 1'b1;
        offer(32'hFFF0_0093, 64'h0);
        chk("I.imm", {32'd0, a_imm}, 64'hFFFF_FFFF);
        chk("I.fmt", {61'd0, a_fmt}, 64'd1);
        offer(32'hFE00_0EE3, 64'h100);
        chk("B.imm", {32'd0, a_imm}, 64'hFFFF_FFFC);
        chk("B.fmt", {61'd0, a_fmt}, 64'd3);
        chk("B.target", {32'd0, a_tgt}, 64'h0000_00FC);
        offer(32'h0010_006F, 64'h1000);
        chk("J.imm", {32'd0, a_imm}, 64'h800);
        chk("J.fmt", {61'd0, a_fmt}, 64'd5);
        chk("J.target", {32'd0, a_tgt}, 64'h1800);
        chk("J.legacy_illegal", {63'd0, c_ill}, 64'd1);
        offer(32'h8000_00B7, 64'h2000);
        chk("U64.imm", b_imm, 64'hFFFF_FFFF_8000_0000);
        chk("U64.fmt", {61'd0, b_fmt}, 64'd4);
        chk("U64.target", b_tgt, 64'd0);
        offer(32'h0000_0000, 64'h0);
        chk("ill.illegal", {63'd0, a_ill}, 64'd1);
        chk("ill.fmt", {61'd0, a_fmt}, 64'd0);
        chk("ill.imm", {32'd0, a_imm}, 64'd0);
        offer(32'h0000_0033, 64'h0);
        chk("R.illegal", {63'd0, a_ill}, 64'd0);
        chk("R.count", {48'd0, a_cnt}, 64'd1);
        offer(32'h0000_8067, 64'h40);
        offer(32'h1234_5017, 64'h8000_0000_0000_1000);
        in_valid = 1'b0;
        tick();

        // Back-pressure: A, B fill the buffer, C waits on in_ready
        out_ready = 1'b0;
        offer(32'h0050_0113, 64'h10);
        offer(32'h00A1_2023, 64'h14);
        offer(32'h00C0_006F, 64'h18);
        chk("bp.in_ready", {63'd0, a_rdy}, 64'd0);
        chk("bp.hold_imm", {32'd0, a_imm}, 64'd5);
        tick();
        chk("bp.hold_imm2", {32'd0, a_imm}, 64'd5);
        out_ready = 1'b1;
        tick();   // A out, C still blocked
        tick();   // B out, C taken
        in_valid = 1'b0;
        tick();   // C out
        tick();

        // Random mix with random back-pressure
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_instr  = rnd_ops[$urandom_range(0, 7)] | ($urandom & 32'hFFFF_FF80);
            in_pc     = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();

        // Saturation: run the counter to 0xFFFE, then three more illegals
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h0; in_pc = 64'h0;
        while (cnt32 < 16'hFFFE) tick();
        chk("sat.preload", {48'd0, a_cnt}, 64'hFFFE);
        tick(); tick(); tick();
        in_valid = 1'b0;
        tick();
        chk("sat.count", {48'd0, a_cnt}, 64'hFFFF);
        chk("sat.count_lg", {48'd0, c_cnt}, 64'hFFFF);
        tick();

        // Reset while two entries are held; the skid entry must vanish
        out_ready = 1'b0;
        offer(32'h0010_0093, 64'h0);
        offer(32'h0020_0113, 64'h0);
        reset = 1'b1; in_valid = 1'b1; in_instr = 32'h0030_0193;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("rst2.out_valid", {63'd0, a_vld}, 64'd0);
        chk("rst2.in_ready", {63'd0, a_rdy}, 64'd1);
        chk("rst2.count", {48'd0, a_cnt}, 64'd0);
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one 32-bit RISC-V instruction and its PC per handshake and extracts the sign-extended immediate for all base formats (I/load/JALR, S, B, U, J), widened to XLEN. It also computes the PC-relative target and flags illegal opcodes. A 2-entry skid buffer registers the outputs under full valid/ready back-pressure, and a saturating counter tallies accepted illegal instructions.

## Interface
- XLEN, 32: datapath width for imm/pc/target; legal values 32 or 64.
- ENABLE_UJ, 1: 1 = decode LUI/AUIPC/JAL/JALR; 0 = legacy I/L/S/B only, where U/J/JALR opcodes are illegal.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  result held on outputs
- out_ready  in  1  consumer takes result this cycle
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J
- out_target  out  XLEN  pc+imm for B, J, AUIPC; else 0
- out_illegal  out  1  opcode not recognised
- illegal_count  out  16  saturating count of accepted illegal instructions

## Operation
- opc = in_instr[6:0]. Decode table:
  - 0010011, 0000011, 1100111 (JALR): format I, imm = sext(instr[31:20]).
  - 0100011: format S, imm = sext({instr[31:25], instr[11:7]}).
  - 1100011: format B, imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 0110111 (LUI), 0010111 (AUIPC): format U, imm = sext({instr[31:12], 12'b0}).
  - 1101111: format J, imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 0110011 (R): format NONE, imm 0, not illegal.
  - Any other opc: format NONE, imm 0, illegal = 1.
- ENABLE_UJ=0: JALR/LUI/AUIPC/JAL decode as format NONE, imm 0, illegal = 1.
- Sign extension is from the immediate's MSB (always instr[31]) to XLEN.
- Target is computed as in_pc + imm modulo 2^XLEN, with no overflow flag. JALR target is 0, because rs1 is not available here.
- Handshake: accept = in_valid & in_ready; deliver = out_valid & out_ready.
- Two storage registers, main (drives outputs) and skid. States:
  - EMPTY: accept → main, go to ONE.
  - ONE:
    - accept & deliver → main reloads, stay ONE.
    - accept & !deliver → skid, go to TWO.
    - deliver only → EMPTY.
  - TWO: deliver → main ← skid, go to ONE. No accept is possible in TWO.
- in_ready = (state != TWO) & !reset, combinational from the state register.
- out_valid = (state != EMPTY).
- Order is strictly FIFO. Outputs are stable while out_valid & !out_ready.
- illegal_count increments on accept of an illegal instruction, saturates at 0xFFFF, and never wraps.

## Timing
- Latency: accept at edge N → out_valid with that result after edge N, i.e. visible in cycle N+1. Zero-bubble throughput: 1/cycle when out_ready stays high.
- in_ready deasserts only in TWO, so a producer holding in_valid loses no data.
- Reset (sync, takes effect at the next edge) returns:
  - state EMPTY, out_valid 0, in_ready 0 while reset is high and 1 after;
  - out_imm, out_target, out_fmt, out_illegal all 0;
  - illegal_count 0.
- Reset mid-operation discards main and skid contents. Inputs offered in the reset cycle are not accepted and not counted.
- Simultaneous accept+deliver in ONE: new data replaces main at the same edge, with no bubble and no duplicate.
- Counter at 0xFFFF plus an illegal accept: stays 0xFFFF.

## Test plan
- Reset: assert reset 2 cycles with in_valid=1 → out_valid 0, all outputs 0, illegal_count 0, no entry accepted.
- I/B decode, XLEN=32:
  - 0xFFF00093 → imm 0xFFFFFFFF, fmt 1.
  - 0xFE000EE3 with pc 0x100 → imm 0xFFFFFFFC, fmt 3, target 0x000000FC.
- J/U decode:
  - 0x0010006F with pc 0x1000 → imm 0x800, fmt 5, target 0x1800.
  - XLEN=64, 0x800000B7 → imm 0xFFFFFFFF80000000, fmt 4, target 0.
- Back-pressure: out_ready=0, offer A, B, C on consecutive cycles → A and B accepted, in_ready=0 while C is held. Then raise out_ready → A, B, C delivered in order, one per cycle, no drop or duplicate.
- Illegal handling:
  - 0x00000000 → illegal 1, fmt 0, imm 0, count +1.
  - ENABLE_UJ=0 with 0x0010006F → illegal 1.
  - 0x00000033 → illegal 0.
  - Preload to 0xFFFE, then 3 illegal accepts → count 0xFFFF.
- Reset while in TWO → next cycle out_valid 0, in_ready 1, and the pending skid entry is never delivered.
